// File: rtl/pa_cp0_cache_op_seq_pkg.sv
// Shared definitions for the CP0 cache-maintenance sequencer: scope codes, op bits and FSM states.
package pa_cp0_cache_op_seq_pkg;

    localparam logic [1:0] CACHE_ALL    = 2'b00;
    localparam logic [1:0] CACHE_SETWAY = 2'b01;
    localparam logic [1:0] CACHE_PA     = 2'b10;
    localparam logic [1:0] CACHE_RSVD   = 2'b11;

    localparam int unsigned OP_CLR = 0;
    localparam int unsigned OP_INV = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WALK   = 2'b01,
        SINGLE = 2'b10,
        DONE   = 2'b11
    } seq_state_e;

endpackage

// File: rtl/pa_cp0_cache_op_cnt.sv
// Set-index / way counter; way is the fast-moving digit so a walk visits both ways of a set back to back.
module pa_cp0_cache_op_cnt #(
    parameter int unsigned INDEX_W = 7,
    parameter int unsigned WAY_W   = 1
) (
    input  logic               cpuclk,
    input  logic               cpurst_b,
    input  logic               load,
    input  logic [INDEX_W-1:0] load_idx,
    input  logic [WAY_W-1:0]   load_way,
    input  logic               inc,
    output logic [INDEX_W-1:0] idx,
    output logic [WAY_W-1:0]   way,
    output logic               last
);

    localparam logic [INDEX_W-1:0] IdxOne = 1;
    localparam logic [WAY_W-1:0]   WayOne = 1;

    logic [INDEX_W-1:0] idx_q;
    logic [WAY_W-1:0]   way_q;

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            idx_q <= '0;
            way_q <= '0;
        end else if (load) begin
            idx_q <= load_idx;
            way_q <= load_way;
        end else if (inc) begin
            if (&way_q) begin
                way_q <= '0;
                idx_q <= idx_q + IdxOne;
            end else begin
                way_q <= way_q + WayOne;
            end
        end
    end

    assign idx  = idx_q;
    assign way  = way_q;
    assign last = (&idx_q) && (&way_q);

endmodule

// File: rtl/pa_cp0_cache_op_seq.sv
// Expands one CP0 cache-maintenance command (ALL / SETWAY / PA) into line operations on a
// valid/ready port and pulses cmd_done once the last line operation has been accepted.
module pa_cp0_cache_op_seq
    import pa_cp0_cache_op_seq_pkg::*;
#(
    parameter int unsigned INDEX_W  = 7,
    parameter int unsigned WAY_W    = 1,
    parameter int unsigned OFFSET_W = 4
) (
    input  logic               cpuclk,
    input  logic               cpurst_b,
    input  logic               cmd_req,
    input  logic [1:0]         cmd_type,
    input  logic [1:0]         cmd_op,
    input  logic [31:0]        cmd_addr,
    output logic               cmd_busy,
    output logic               cmd_done,
    output logic               line_vld,
    input  logic               line_rdy,
    output logic               line_pa,
    output logic [INDEX_W-1:0] line_idx,
    output logic [WAY_W-1:0]   line_way,
    output logic [31:0]        line_addr,
    output logic [1:0]         line_op
);

    seq_state_e state_q, state_d;

    logic               pa_q;
    logic [31:0]        addr_q;
    logic [1:0]         op_q;
    logic               capture;
    logic               cnt_load;
    logic               cnt_inc;
    logic               cnt_last;
    logic [INDEX_W-1:0] ld_idx;
    logic [WAY_W-1:0]   ld_way;
    logic               xfer;
    logic               is_nop;

    assign line_vld = (state_q == WALK) || (state_q == SINGLE);
    assign xfer     = line_vld && line_rdy;
    assign is_nop   = !(cmd_op[OP_CLR] || cmd_op[OP_INV]) || (cmd_type == CACHE_RSVD);

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        ld_idx   = cmd_addr[OFFSET_W +: INDEX_W];
        ld_way   = cmd_addr[31 -: WAY_W];
        unique case (state_q)
            IDLE: begin
                if (cmd_req) begin
                    capture  = 1'b1;
                    cnt_load = 1'b1;
                    if (is_nop) begin
                        state_d = DONE;
                    end else if (cmd_type == CACHE_ALL) begin
                        ld_idx  = '0;
                        ld_way  = '0;
                        state_d = WALK;
                    end else begin
                        state_d = SINGLE;
                    end
                end
            end
            WALK: begin
                if (xfer) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = DONE;
                    end
                end
            end
            SINGLE: begin
                if (xfer) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= IDLE;
            pa_q    <= 1'b0;
            addr_q  <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                pa_q   <= (cmd_type == CACHE_PA);
                addr_q <= {cmd_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
                op_q   <= cmd_op;
            end
        end
    end

    pa_cp0_cache_op_cnt #(
        .INDEX_W (INDEX_W),
        .WAY_W   (WAY_W)
    ) u_cnt (
        .cpuclk   (cpuclk),
        .cpurst_b (cpurst_b),
        .load     (cnt_load),
        .load_idx (ld_idx),
        .load_way (ld_way),
        .inc      (cnt_inc),
        .idx      (line_idx),
        .way      (line_way),
        .last     (cnt_last)
    );

    assign cmd_busy  = (state_q != IDLE);
    assign cmd_done  = (state_q == DONE);
    // Scope flag stays captured after the command; only advertise it with a live operation.
    assign line_pa   = pa_q && line_vld;
    assign line_addr = addr_q;
    assign line_op   = op_q;

endmodule

// File: tb/tb_pa_cp0_cache_op_seq.sv
// Directed bench for pa_cp0_cache_op_seq: expected line operations are queued when a command is
// issued and checked in order as the DUT hands them over.
module tb_pa_cp0_cache_op_seq;

    localparam int NI = 128;
    localparam int NW = 2;

    typedef struct packed {
        logic [6:0]  idx;
        logic        way;
        logic        pa;
        logic [31:0] addr;
        logic [1:0]  op;
    } exp_t;

    logic        cpuclk = 1'b0;
    logic        cpurst_b;
    logic        cmd_req;
    logic [1:0]  cmd_type;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic        cmd_busy;
    logic        cmd_done;
    logic        line_vld;
    logic        line_rdy;
    logic        line_pa;
    logic [6:0]  line_idx;
    logic        line_way;
    logic [31:0] line_addr;
    logic [1:0]  line_op;

    int n_chk    = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;
    int vld_seen = 0;
    exp_t q[$];
    exp_t e;

    always #5 cpuclk = ~cpuclk;

    pa_cp0_cache_op_seq #(
        .INDEX_W  (7),
        .WAY_W    (1),
        .OFFSET_W (4)
    ) dut (
        .cpuclk    (cpuclk),
        .cpurst_b  (cpurst_b),
        .cmd_req   (cmd_req),
        .cmd_type  (cmd_type),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_busy  (cmd_busy),
        .cmd_done  (cmd_done),
        .line_vld  (line_vld),
        .line_rdy  (line_rdy),
        .line_pa   (line_pa),
        .line_idx  (line_idx),
        .line_way  (line_way),
        .line_addr (line_addr),
        .line_op   (line_op)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpuclk);
        #1;
    endtask

    task automatic push(input int idx, input int way, input logic pa, input logic [31:0] addr,
                        input logic [1:0] op);
        exp_t x;
        x.idx  = idx[6:0];
        x.way  = way[0];
        x.pa   = pa;
        x.addr = addr;
        x.op   = op;
        q.push_back(x);
    endtask

    task automatic push_walk(input logic [1:0] op);
        for (int i = 0; i < NI; i++) begin
            for (int w = 0; w < NW; w++) begin
                push(i, w, 1'b0, 32'h0, op);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'b0, cmd_busy}, 32'd0);
        check({tag, "_done"}, {31'b0, cmd_done}, 32'd0);
        check({tag, "_vld"}, {31'b0, line_vld}, 32'd0);
        check({tag, "_pa"}, {31'b0, line_pa}, 32'd0);
        check({tag, "_idx"}, {25'b0, line_idx}, 32'd0);
        check({tag, "_way"}, {31'b0, line_way}, 32'd0);
        check({tag, "_addr"}, line_addr, 32'd0);
        check({tag, "_op"}, {30'b0, line_op}, 32'd0);
    endtask

    // Scoreboard side: every accepted line operation must be the next queued expectation.
    always @(negedge cpuclk) begin
        if (cmd_done) done_cnt++;
        if (line_vld) vld_seen++;
        if (line_vld && line_rdy) begin
            xfer_cnt++;
            if (q.size() == 0) begin
                check("xfer_unexpected", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("xfer_pa", {31'b0, line_pa}, {31'b0, e.pa});
                check("xfer_op", {30'b0, line_op}, {30'b0, e.op});
                if (e.pa) begin
                    check("xfer_addr", line_addr, e.addr);
                end else begin
                    check("xfer_idx", {25'b0, line_idx}, {25'b0, e.idx});
                    check("xfer_way", {31'b0, line_way}, {31'b0, e.way});
                end
            end
        end
    end

    initial begin
        int cyc;
        int x0;
        int d0;
        int v0;

        cpurst_b = 1'b0;
        cmd_req  = 1'b0;
        cmd_type = 2'b00;
        cmd_op   = 2'b00;
        cmd_addr = 32'h0;
        line_rdy = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        cpurst_b = 1'b1;
        tick();
        check("idle_busy", {31'b0, cmd_busy}, 32'd0);

        // PA invalidate, single line
        line_rdy = 1'b1;
        cmd_req  = 1'b1;
        cmd_type = 2'b10;
        cmd_op   = 2'b10;
        cmd_addr = 32'h8000_123C;
        push(0, 0, 1'b1, 32'h8000_1230, 2'b10);
        tick();
        cmd_req = 1'b0;
        check("pa_vld", {31'b0, line_vld}, 32'd1);
        check("pa_pa", {31'b0, line_pa}, 32'd1);
        check("pa_addr", line_addr, 32'h8000_1230);
        check("pa_op", {30'b0, line_op}, 32'd2);
        tick();
        check("pa_done", {31'b0, cmd_done}, 32'd1);
        check("pa_done_vld", {31'b0, line_vld}, 32'd0);
        tick();
        check("pa_idle_done", {31'b0, cmd_done}, 32'd0);
        check("pa_idle_busy", {31'b0, cmd_busy}, 32'd0);

        // SETWAY clean with three cycles of back-pressure
        line_rdy = 1'b0;
        cmd_req  = 1'b1;
        cmd_type = 2'b01;
        cmd_op   = 2'b01;
        cmd_addr = 32'h8000_0070;
        push(7, 1, 1'b0, 32'h0, 2'b01);
        tick();
        cmd_req  = 1'b0;
        cmd_addr = 32'h0000_0000;
        for (int k = 0; k < 3; k++) begin
            check("sw_vld", {31'b0, line_vld}, 32'd1);
            check("sw_idx", {25'b0, line_idx}, 32'd7);
            check("sw_way", {31'b0, line_way}, 32'd1);
            check("sw_pa", {31'b0, line_pa}, 32'd0);
            check("sw_op", {30'b0, line_op}, 32'd1);
            if (k == 2) line_rdy = 1'b1;
            tick();
        end
        check("sw_done", {31'b0, cmd_done}, 32'd1);
        check("sw_q_empty", q.size(), 32'd0);
        tick();

        // ALL clean+invalidate, no back-pressure
        x0       = xfer_cnt;
        line_rdy = 1'b1;
        cmd_req  = 1'b1;
        cmd_type = 2'b00;
        cmd_op   = 2'b11;
        cmd_addr = 32'hDEAD_BEEF;
        push_walk(2'b11);
        tick();
        cmd_req = 1'b0;
        cyc = 0;
        while (!cmd_done && cyc < 1000) begin
            tick();
            cyc++;
        end
        check("all_done_latency", cyc, 32'd256);
        check("all_xfers", xfer_cnt - x0, 32'd256);
        check("all_q_empty", q.size(), 32'd0);
        tick();

        // ALL with random back-pressure and cmd_* noise mid-walk
        x0       = xfer_cnt;
        line_rdy = 1'b0;
        cmd_req  = 1'b1;
        cmd_type = 2'b00;
        cmd_op   = 2'b01;
        cmd_addr = 32'h0;
        push_walk(2'b01);
        tick();
        cyc = 0;
        while (!cmd_done && cyc < 5000) begin
            line_rdy = 1'($urandom_range(0, 1));
            cmd_req  = 1'($urandom_range(0, 1));
            cmd_type = 2'($urandom);
            cmd_op   = 2'($urandom);
            cmd_addr = $urandom;
            tick();
            cyc++;
        end
        cmd_req = 1'b0;
        check("rand_done_seen", {31'b0, cmd_done}, 32'd1);
        check("rand_xfers", xfer_cnt - x0, 32'd256);
        check("rand_q_empty", q.size(), 32'd0);
        tick();
        check("rand_idle_busy", {31'b0, cmd_busy}, 32'd0);

        // Reserved type and empty op: completion only, no line traffic
        line_rdy = 1'b1;
        v0 = vld_seen;
        cmd_req  = 1'b1;
        cmd_type = 2'b11;
        cmd_op   = 2'b11;
        tick();
        cmd_req = 1'b0;
        check("rsvd_done", {31'b0, cmd_done}, 32'd1);
        check("rsvd_busy", {31'b0, cmd_busy}, 32'd1);
        check("rsvd_vld", {31'b0, line_vld}, 32'd0);
        tick();
        check("rsvd_after_done", {31'b0, cmd_done}, 32'd0);
        check("rsvd_after_busy", {31'b0, cmd_busy}, 32'd0);
        cmd_req  = 1'b1;
        cmd_type = 2'b10;
        cmd_op   = 2'b00;
        tick();
        cmd_req = 1'b0;
        check("nop_done", {31'b0, cmd_done}, 32'd1);
        check("nop_busy", {31'b0, cmd_busy}, 32'd1);
        check("nop_vld", {31'b0, line_vld}, 32'd0);
        tick();
        check("nop_after_busy", {31'b0, cmd_busy}, 32'd0);
        check("nop_no_vld", vld_seen - v0, 32'd0);

        // Reset in the middle of a walk
        line_rdy = 1'b1;
        cmd_req  = 1'b1;
        cmd_type = 2'b00;
        cmd_op   = 2'b11;
        cmd_addr = 32'h1234_5670;
        push_walk(2'b11);
        tick();
        cmd_req = 1'b0;
        cyc = 0;
        while (line_idx != 7'd5 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("rst_reached_idx5", {25'b0, line_idx}, 32'd5);
        d0 = done_cnt;
        #2;
        cpurst_b = 1'b0;
        #1;
        check_all_zero("rst_async");
        q.delete();
        repeat (2) tick();
        cpurst_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_idle_busy", {31'b0, cmd_busy}, 32'd0);
            check("rst_idle_vld", {31'b0, line_vld}, 32'd0);
        end
        check("rst_no_done", done_cnt - d0, 32'd0);
        check("total_done", done_cnt, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pa_cp0_cache_op_seq.md
Name: pa_cp0_cache_op_seq

Overview:
Sequencer between the CP0 cache-instruction decode and one L1 cache tag/data maintenance port (one instance for dcache, one for icache).
- Accepts one cache-maintenance command: scope ALL / SETWAY / PA, with clean and/or invalidate.
- Expands it into per-line operations on a valid/ready line port.
- Pulses done when the last line operation is accepted; the decode stage uses this to release its stall.

Parameters:
INDEX_W, 7, set-index width (2^INDEX_W sets)
WAY_W, 1, way-number width (2^WAY_W ways)
OFFSET_W, 4, line-offset width in bytes (16-byte line)

Ports:
cpuclk  input  1  clock
cpurst_b  input  1  asynchronous active-low reset
cmd_req  input  1  command request, level, sampled only in IDLE
cmd_type  input  2  00=ALL, 01=SETWAY, 10=PA, 11=reserved
cmd_op  input  2  bit0=clean, bit1=invalidate
cmd_addr  input  32  PA for PA scope; for SETWAY: index=cmd_addr[OFFSET_W+:INDEX_W], way=cmd_addr[31-:WAY_W]
cmd_busy  output  1  command in progress (state != IDLE)
cmd_done  output  1  one-cycle completion pulse
line_vld  output  1  line operation valid
line_rdy  input  1  cache accepts line operation
line_pa  output  1  1 = address lookup (line_addr); 0 = index/way access
line_idx  output  INDEX_W  set index
line_way  output  WAY_W  way
line_addr  output  32  line-aligned PA (low OFFSET_W bits zero)
line_op  output  2  copy of captured cmd_op

Behaviour:
- Reset (async, cpurst_b low): state=IDLE. All outputs 0: cmd_busy, cmd_done, line_vld, line_pa, line_idx, line_way, line_addr, line_op.
- States: IDLE, WALK, SINGLE, DONE.
- IDLE with cmd_req=1: capture type, op and addr into registers.
  - op==00 or type==11 -> DONE. No line operation is issued.
  - type ALL -> WALK with idx=0, way=0.
  - type SETWAY -> SINGLE with idx/way taken from cmd_addr fields.
  - type PA -> SINGLE with line_addr = {cmd_addr[31:OFFSET_W], 0}.
- line_vld=1 exactly in WALK and SINGLE. line_pa=1 only for PA scope.
- line_idx, line_way, line_addr and line_op are registered and stay stable while line_vld && !line_rdy.
- Transfer occurs when line_vld && line_rdy.
- SINGLE: on transfer -> DONE.
- WALK: on transfer, way increments first.
  - At way all-ones: way wraps to 0 and idx increments.
  - Transfer at idx all-ones and way all-ones -> DONE, with idx/way wrapping to 0.
- DONE: cmd_done=1 for one cycle, then -> IDLE. cmd_busy=1 in WALK, SINGLE and DONE.
- cmd_req is ignored outside IDLE; changes to the cmd_* inputs mid-operation have no effect.
- Requester drops cmd_req in the cycle it sees cmd_done. If cmd_req is still 1 in IDLE, a new command starts.
- Latency: cmd_req sampled in cycle n.
  - First line_vld in cycle n+1.
  - With line_rdy=1 continuously, SINGLE gives cmd_done at n+2; ALL gives cmd_done at n+1+2^(INDEX_W+WAY_W).
  - Nop/reserved commands give cmd_done at n+1.
- line_rdy back-pressure stalls the walk indefinitely, with no timeout.
- Reset asserted mid-walk aborts immediately to IDLE with no done pulse.

Decomposition:
- Shared package holds:
  - scope constants CACHE_ALL=2'b00, CACHE_SETWAY=2'b01, CACHE_PA=2'b10
  - op bit positions OP_CLR=0, OP_INV=1
  - state encodings IDLE/WALK/SINGLE/DONE
- One natural sub-module: pa_cp0_cache_op_cnt, the index/way counter.
  - Inputs: load, load value, inc.
  - Outputs: idx, way, last (idx and way both all-ones).

Test Plan:
- Reset mid-WALK (cpurst_b low at idx=5) -> all outputs 0 asynchronously. After release, state IDLE and no cmd_done.
- PA invalidate: cmd_addr=0x8000_123C, op=10, line_rdy=1 -> line_vld one cycle with line_pa=1, line_addr=0x8000_1230, line_op=10; cmd_done in the following cycle.
- SETWAY clean: cmd_addr=0x8000_0070 -> line_idx=7, line_way=1, line_pa=0.
  - line_rdy held 0 for 3 cycles -> outputs stable for 3 cycles, then transfer, then cmd_done.
- ALL clean+inv with defaults and line_rdy=1 -> exactly 256 transfers in order (idx0,w0),(idx0,w1),(idx1,w0)…(idx127,w1); cmd_done cycle after the last.
- ALL with random line_rdy -> transfer count still 256, no idx/way skipped or repeated; cmd_req toggling mid-walk ignored.
- Reserved type 11 and op=00 -> cmd_done at n+1, line_vld never asserted; cmd_busy high only during the DONE cycle.
